// File: rtl/btn_pkg.sv
// btn_pkg
//   Shared definitions for the push-button conditioner: debounce FSM state
//   encoding and the default timing values for the 50 MHz board.
//   No ports.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_UP     = 2'd0,
      ST_CHK_DN = 2'd1,
      ST_DOWN   = 2'd2,
      ST_CHK_UP = 2'd3
   } btn_state_e;

   // 20 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int CNT_W_DEF           = 20;
   localparam int REPEAT_DELAY_DEF    = 25_000_000;
   localparam int REPEAT_PERIOD_DEF   = 5_000_000;

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
//   Conditions one raw active-low push-button: 2-FF synchronizer, debounce
//   FSM with acceptance counter, registered one-cycle press/release pulses.
//   Optional auto-repeat of the press pulse while held: macro BTN_AUTOREPEAT_EN.
// Ports
//   clk_i        system clock
//   reset_i      synchronous, active-high
//   btn_n_raw_i  raw button, active-low, asynchronous to clk_i
//   level_n_o    debounced level, active-low
//   press_o      one-cycle pulse on accepted press (and repeats)
//   rel_o        one-cycle pulse on accepted release
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_UP     | released and stable
// ST_CHK_DN | low seen, counting stable-low cycles
// ST_DOWN   | pressed and stable (repeat timer runs here)
// ST_CHK_UP | high seen, counting stable-high cycles
module debounce_cell
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_n_raw_i,
   output logic level_n_o,
   output logic press_o,
   output logic rel_o
);

   localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2)
                           && (64'(DEBOUNCE_CYCLES) < (64'd1 << CNT_W))
                           && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   if (!PARAMS_OK) begin : g_bad_params
      $error("debounce_cell: illegal timing parameters");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_n_q, level_n_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX) + 1;

   // Down-counter: loaded on every entry to DOWN, pulse at terminal count 0.
   logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_n_d = level_n_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_d     = rpt_q;
`endif
      case (state_q)
         ST_UP: begin
            if (!sync2_q) begin
               state_d = ST_CHK_DN;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_CHK_DN: begin
            if (sync2_q) begin
               state_d = ST_UP;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_DOWN;
               cnt_d     = '0;
               level_n_d = 1'b0;
               press_d   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               rpt_d     = RPT_W'(REPEAT_DELAY - 1);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DOWN: begin
            if (sync2_q) begin
               state_d = ST_CHK_UP;
               cnt_d   = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
               rpt_d   = '0;
            end else if (rpt_q == '0) begin
               press_d = 1'b1;
               rpt_d   = RPT_W'(REPEAT_PERIOD - 1);
            end else begin
               rpt_d   = rpt_q - RPT_W'(1);
`endif
            end
         end
         ST_CHK_UP: begin
            if (!sync2_q) begin
               // bounce back to held: no pulse, repeat restarts from full delay
               state_d = ST_DOWN;
               cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
               rpt_d   = RPT_W'(REPEAT_DELAY - 1);
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_UP;
               cnt_d     = '0;
               level_n_d = 1'b1;
               rel_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_UP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= ST_UP;
         cnt_q     <= '0;
         level_n_q <= 1'b1;
         press_q   <= 1'b0;
         rel_q     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q     <= '0;
`endif
      end else begin
         sync1_q   <= btn_n_raw_i;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_n_q <= level_n_d;
         press_q   <= press_d;
         rel_q     <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q     <= rpt_d;
`endif
      end
   end

   assign level_n_o = level_n_q;
   assign press_o   = press_q;
   assign rel_o     = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Input stage ahead of the game top: N_BTN independent debounce cells,
//   one per raw active-low push-button. Outputs are concatenated per button.
//   Optional press auto-repeat: macro BTN_AUTOREPEAT_EN.
// Ports
//   clk          system clock, 50 MHz
//   reset        synchronous, active-high
//   btn_n_raw    raw buttons, active-low, asynchronous
//   btn_level_n  debounced levels, active-low
//   btn_press    one-cycle pulse per accepted press (plus repeats)
//   btn_release  one-cycle pulse per accepted release
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n_raw,
   output logic [N_BTN-1:0] btn_level_n,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cell (
         .clk_i       (clk),
         .reset_i     (reset),
         .btn_n_raw_i (btn_n_raw[i]),
         .level_n_o   (btn_level_n[i]),
         .press_o     (btn_press[i]),
         .rel_o       (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int CW = 4;
   localparam int RD = 20;
   localparam int RP = 6;
   // raw change driven while cyc==c shows up on the outputs once cyc==c+LAT
   localparam int LAT = DB + 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] raw = '0;
   logic [N-1:0] level_n, press, release_p;

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (CW),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_n_raw   (raw),
      .btn_level_n (level_n),
      .btn_press   (press),
      .btn_release (release_p)
   );

   typedef struct {
      int           cyc;
      logic [N-1:0] p;
      logic [N-1:0] r;
   } exp_t;

   typedef struct {
      int btn;
      int low_len;
      bit accept;
   } vec_t;

   exp_t         exp_q[$];
   int           cyc = 0;
   logic         rst_d1 = 1'b1;
   logic [N-1:0] exp_level = '1;
   int           n_checks = 0;
   int           n_err = 0;
   int           press3_cnt = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_d1 <= reset;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
      end
   endtask

   task automatic exp_push(input int c, input logic [N-1:0] p, input logic [N-1:0] r);
      exp_t e;
      e.cyc = c; e.p = p; e.r = r;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard: pop every entry due this cycle and compare against outputs
   always @(negedge clk) begin
      logic [N-1:0] ep, er;
      if (cyc >= 1) begin
         if (press[3] === 1'b1) press3_cnt++;
         if (rst_d1) begin
            exp_level = '1;
            check("reset_level", 32'(level_n), 32'(exp_level));
            check("reset_pulses", 32'({press, release_p}), 32'd0);
         end else begin
            ep = '0;
            er = '0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
               if (exp_q[i].cyc == cyc) begin
                  ep |= exp_q[i].p;
                  er |= exp_q[i].r;
                  exp_q.delete(i);
               end else if (exp_q[i].cyc < cyc) begin
                  check("overdue_event", 32'(exp_q[i].cyc), 32'(cyc));
                  exp_q.delete(i);
               end
            end
            if (ep != '0 || er != '0 || press != '0 || release_p != '0) begin
               check("press", 32'(press), 32'(ep));
               check("release", 32'(release_p), 32'(er));
            end
            exp_level = (exp_level & ~ep) | er;
            check("level_n", 32'(level_n), 32'(exp_level));
         end
      end
   end

   initial begin
      vec_t vecs[6];
      int   t0;
      int   exp_p3;

      vecs[0] = '{btn: 2, low_len: 5,  accept: 1'b0};
      vecs[1] = '{btn: 2, low_len: 7,  accept: 1'b0};
      vecs[2] = '{btn: 2, low_len: 8,  accept: 1'b1};
      vecs[3] = '{btn: 2, low_len: 12, accept: 1'b1};
      vecs[4] = '{btn: 1, low_len: 3,  accept: 1'b0};
      vecs[5] = '{btn: 0, low_len: 9,  accept: 1'b1};

      // 1: all buttons held through reset, accepted together after release
      raw   = '0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      exp_push(cyc + LAT, 4'b1111, 4'b0000);
      tick(15);
      raw = '1;
      exp_push(cyc + LAT, 4'b0000, 4'b1111);
      tick(15);

      // 2: single press with exact latency, release 30 cycles later
      raw[0] = 1'b0;
      t0 = cyc;
      exp_push(t0 + LAT, 4'b0001, 4'b0000);
      tick(30);
      raw[0] = 1'b1;
      exp_push(t0 + 30 + LAT, 4'b0000, 4'b0001);
      tick(15);

      // table: low pulses of various lengths; 8+ cycles are accepted
      for (int i = 0; i < 6; i++) begin
         raw[vecs[i].btn] = 1'b0;
         t0 = cyc;
         if (vecs[i].accept) begin
            exp_push(t0 + LAT, 4'(1 << vecs[i].btn), 4'b0000);
            exp_push(t0 + vecs[i].low_len + LAT, 4'b0000, 4'(1 << vecs[i].btn));
         end
         tick(vecs[i].low_len);
         raw[vecs[i].btn] = 1'b1;
         tick(20);
      end

      // 4: reset during the release check of button 1
      raw[1] = 1'b0;
      t0 = cyc;
      exp_push(t0 + LAT, 4'b0010, 4'b0000);
      tick(15);
      raw[1] = 1'b1;
      tick(5);
      reset  = 1'b1;
      raw[1] = 1'b0;
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      exp_push(cyc + LAT, 4'b0010, 4'b0000);
      tick(15);
      raw[1] = 1'b1;
      exp_push(cyc + LAT, 4'b0000, 4'b0010);
      tick(15);

      // 5: hold button 3 low for 60 cycles
      press3_cnt = 0;
      raw[3] = 1'b0;
      t0 = cyc;
      exp_push(t0 + LAT, 4'b1000, 4'b0000);
`ifdef BTN_AUTOREPEAT_EN
      // DOWN is left at the edge ending cycle t0+63; repeats due strictly before
      for (int e = t0 + LAT + RD; e <= t0 + 62; e += RP)
         exp_push(e, 4'b1000, 4'b0000);
      exp_p3 = 7;
`else
      exp_p3 = 1;
`endif
      tick(60);
      raw[3] = 1'b1;
      exp_push(t0 + 60 + LAT, 4'b0000, 4'b1000);
      tick(20);
      check("press3_count", 32'(press3_cnt), 32'(exp_p3));

      check("events_pending", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
